muldiv_sched: RTL and testbench

MULDIV_SCHED -- requirements
Module: muldiv_sched

---
 rtl/muldiv_sched.sv | 111 +++++++++++
 tb/tb_muldiv_sched.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sched.sv
// Sequencer for a shared multiply/divide unit: starts the selected engine, waits for
// its end flag within a cycle budget, then writes HI/LO or raises an exception.
module muldiv_sched #(
    parameter int TIMEOUT = 48
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] b_in,
    input  logic        mult_end,
    input  logic        div_end,
    output logic        mult_start,
    output logic        div_start,
    output logic        div_clear,
    output logic        hi_w,
    output logic        lo_w,
    output logic        sel_div,
    output logic        busy,
    output logic        done,
    output logic        exc,
    output logic        exc_cause
);

    // state    | meaning
    // IDLE     | waiting for start
    // MULT_RUN | multiplier running, cnt counts run cycles
    // DIV_RUN  | divider running, cnt counts run cycles
    // WRITE    | HI/LO write-enable cycle
    // DONE     | completion pulse cycle
    // EXC      | exception pulse cycle (divide-by-zero or timeout)
    typedef enum logic [2:0] {IDLE, MULT_RUN, DIV_RUN, WRITE, DONE, EXC} state_t;

    localparam logic [5:0] CNT_LAST = 6'(TIMEOUT - 1);

    state_t     state;
    logic [5:0] cnt;
    logic       op_q;
    logic       run_end;

    // An end seen in the first run cycle belongs to a previous operation.
    assign run_end = (cnt != 6'd0) &&
                     (((state == MULT_RUN) && mult_end) || ((state == DIV_RUN) && div_end));
    assign sel_div = op_q;
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 6'd0;
            op_q       <= 1'b0;
            mult_start <= 1'b0;
            div_start  <= 1'b0;
            div_clear  <= 1'b0;
            hi_w       <= 1'b0;
            lo_w       <= 1'b0;
            done       <= 1'b0;
            exc        <= 1'b0;
            exc_cause  <= 1'b0;
        end else begin
            mult_start <= 1'b0;
            div_start  <= 1'b0;
            div_clear  <= 1'b0;
            hi_w       <= 1'b0;
            lo_w       <= 1'b0;
            done       <= 1'b0;
            exc        <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= 6'd0;
                    if (start) begin
                        op_q <= op;
                        if (!op) begin
                            state      <= MULT_RUN;
                            mult_start <= 1'b1;
                        end else if (b_in != 32'd0) begin
                            state     <= DIV_RUN;
                            div_start <= 1'b1;
                        end else begin
                            state     <= EXC;
                            exc       <= 1'b1;
                            exc_cause <= 1'b0;
                        end
                    end
                end
                MULT_RUN, DIV_RUN: begin
                    if (run_end) begin
                        state <= WRITE;
                        hi_w  <= 1'b1;
                        lo_w  <= 1'b1;
                    end else if (cnt == CNT_LAST) begin
                        state     <= EXC;
                        exc       <= 1'b1;
                        exc_cause <= 1'b1;
                        div_clear <= op_q;
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end
                WRITE: begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                DONE:    state <= IDLE;
                EXC:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sched.sv
// Scoreboard bench for muldiv_sched: driver pushes the expected outcome of each
// operation, a negedge monitor pops and compares whenever the DUT writes, completes or excepts.
module tb_muldiv_sched;
    localparam int T = 48;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [31:0] b_in = 32'd0;
    logic        mult_end = 1'b0;
    logic        div_end = 1'b0;
    logic        mult_start, div_start, div_clear, hi_w, lo_w;
    logic        sel_div, busy, done, exc, exc_cause;

    muldiv_sched #(.TIMEOUT(T)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .b_in(b_in),
        .mult_end(mult_end), .div_end(div_end), .mult_start(mult_start),
        .div_start(div_start), .div_clear(div_clear), .hi_w(hi_w), .lo_w(lo_w),
        .sel_div(sel_div), .busy(busy), .done(done), .exc(exc), .exc_cause(exc_cause)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit is_exc;
        bit cause;
        bit clr;
        bit sel;
        int at;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;
    int ms_seen = 0, ds_seen = 0, ms_exp = 0, ds_exp = 0;

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            ms_seen += int'(mult_start);
            ds_seen += int'(div_start);
            if (int'(hi_w) + int'(lo_w) + int'(done) + int'(exc) > 0 &&
                (done || exc) && (hi_w || lo_w))
                chk("exclusive_pulses", 1, 0);
            if (done && exc) chk("done_and_exc", 1, 0);
            if (div_clear && !exc) chk("div_clear_outside_exc", 1, 0);
            if (hi_w || lo_w) begin
                if (sb.size() == 0) chk("unexpected_write", 1, 0);
                else begin
                    chk("write_kind", 0, int'(sb[0].is_exc));
                    chk("hi_lo_both", int'(hi_w & lo_w), 1);
                    chk("write_sel_div", int'(sel_div), int'(sb[0].sel));
                    chk("write_cycle", cyc, sb[0].at - 1);
                end
            end
            if (done || exc) begin
                if (sb.size() == 0) chk("unexpected_end_event", 1, 0);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("event_kind_exc", int'(exc), int'(e.is_exc));
                    chk("event_cycle", cyc, e.at);
                    chk("event_sel_div", int'(sel_div), int'(e.sel));
                    if (exc) begin
                        chk("exc_cause", int'(exc_cause), int'(e.cause));
                        chk("div_clear", int'(div_clear), int'(e.clr));
                    end
                end
            end
        end
    end

    // e: run cycle at which the correct end is raised; stale adds an end in run cycle 0;
    // noise toggles the other unit's end and re-pulses start/op/b_in while busy.
    task automatic run_txn(input bit o, input logic [31:0] b, input int e,
                           input bit stale, input bit noise, input int rst_at);
        int   a;
        int   j;
        exp_t x;
        bit   zero_div;
        @(negedge clk);
        start = 1'b1; op = o; b_in = b; mult_end = 1'b0; div_end = 1'b0;
        @(posedge clk);
        #1;
        a = cyc;
        zero_div = o && (b == 32'd0);
        x.sel = o;
        if (zero_div) begin
            x.is_exc = 1; x.cause = 0; x.clr = 0; x.at = a;
        end else if (e >= 1 && e <= T - 1) begin
            x.is_exc = 0; x.cause = 0; x.clr = 0; x.at = a + e + 2;
        end else begin
            x.is_exc = 1; x.cause = 1; x.clr = o; x.at = a + T;
        end
        sb.push_back(x);
        if (!o) ms_exp++;
        else if (!zero_div) ds_exp++;
        chk("accept_mult_start", int'(mult_start), int'(!o));
        chk("accept_div_start", int'(div_start), int'(o && !zero_div));
        chk("accept_busy", int'(busy), 1);
        chk("accept_sel_div", int'(sel_div), int'(o));
        j = 0;
        while (1) begin
            if (j == rst_at) begin
                #1 reset = 1'b1;
                #1;
                chk("async_reset_outputs",
                    int'({mult_start, div_start, div_clear, hi_w, lo_w, sel_div,
                          busy, done, exc, exc_cause}), 0);
                void'(sb.pop_back());
                repeat (3) @(posedge clk);
                @(negedge clk);
                reset = 1'b0;
                break;
            end
            if (j > 0 && !busy) break;
            if (j > 200) begin
                chk("busy_bounded", j, 200);
                break;
            end
            begin
                bit good;
                bit other;
                good  = (j == e) || (stale && j == 0);
                other = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                mult_end = o ? other : good;
                div_end  = o ? good : other;
                start    = noise ? ($urandom_range(0, 2) == 0) : 1'b0;
                op       = noise ? 1'($urandom_range(0, 1)) : o;
                b_in     = noise ? $urandom : b;
            end
            @(posedge clk);
            #1;
            j++;
        end
        start = 1'b0; mult_end = 1'b0; div_end = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #1;
        chk("reset_state",
            int'({mult_start, div_start, div_clear, hi_w, lo_w, sel_div,
                  busy, done, exc, exc_cause}), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        run_txn(1'b0, 32'h1234, 32, 1'b0, 1'b0, -1);
        run_txn(1'b1, 32'd7, 5, 1'b0, 1'b0, -1);
        run_txn(1'b1, 32'd0, 5, 1'b0, 1'b0, -1);
        run_txn(1'b0, 32'd3, 99, 1'b0, 1'b0, -1);
        run_txn(1'b1, 32'd3, 99, 1'b0, 1'b0, -1);
        run_txn(1'b0, 32'd1, 3, 1'b1, 1'b1, -1);
        run_txn(1'b1, 32'd9, 30, 1'b0, 1'b0, 10);
        run_txn(1'b1, 32'd9, 4, 1'b0, 1'b0, -1);
        run_txn(1'b0, 32'd1, T - 1, 1'b0, 1'b0, -1);
        run_txn(1'b1, 32'd2, T, 1'b0, 1'b1, -1);
        run_txn(1'b1, 32'd2, 1, 1'b1, 1'b1, -1);
        run_txn(1'b0, 32'd2, 0, 1'b1, 1'b0, -1);
        for (int n = 0; n < 40; n++) begin
            bit          ro;
            logic [31:0] rb;
            ro = 1'($urandom_range(0, 1));
            rb = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            run_txn(ro, rb, int'($urandom_range(0, 55)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), -1);
        end
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        chk("mult_start_pulses", ms_seen, ms_exp);
        chk("div_start_pulses", ds_seen, ds_exp);
        chk("idle_at_end", int'(busy), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
